// File: rtl/ov7670_cfg_sequencer.sv
// ov7670_cfg_sequencer
//   Walks a {reg, val} table held in an external registered ROM and writes each
//   entry into the OV7670 through an SCCB/I2C write master. NACKed writes are
//   retried up to MAX_RETRY times. A fixed idle gap separates consecutive writes.
//   A settle delay follows a COM7 soft reset and every delay entry.
//   Table markers: 16'hFFFF ends the table, 16'hFFF0 inserts a SETTLE_MS delay.
// Ports
//   Clk, reset_n          clock, asynchronous active-low reset
//   start                 one-cycle pulse; begins a table pass from IDLE/DONE/ERROR
//   rom_addr / rom_data   table index out, {reg, val} in (one cycle of ROM latency)
//   wr_req .. wr_data     write request to the I2C master, held until wr_ack
//   wr_ack / wr_nack      transaction finished / slave NACKed (qualified by wr_ack)
//   busy, done, error     status; done and error are sticky until the next start
//   err_index             table index of the entry that ran out of retries
module ov7670_cfg_sequencer #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned NUM_REGS    = 128,
    parameter logic [7:0]  DEV_ADDR    = 8'h42,
    parameter int unsigned SETTLE_MS   = 10,
    parameter int unsigned GAP_CYCLES  = 1000,
    parameter int unsigned MAX_RETRY   = 3,
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic          Clk,
    input  logic          reset_n,
    input  logic          start,
    output logic [AW-1:0] rom_addr,
    input  logic [15:0]   rom_data,
    output logic          wr_req,
    output logic [7:0]    wr_dev,
    output logic [7:0]    wr_reg,
    output logic [7:0]    wr_data,
    input  logic          wr_ack,
    input  logic          wr_nack,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] err_index
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam longint unsigned DELAY_CYC = (64'(SETTLE_MS) * 64'(CLK_FREQ_HZ)) / 64'd1000;
    // Terminal values of the shared down-counter; a zero length still spends one cycle.
    localparam logic [31:0] DELAY_LAST = (DELAY_CYC > 1) ? 32'(DELAY_CYC - 1) : 32'd0;
    localparam logic [31:0] GAP_LAST   = (GAP_CYCLES > 1) ? 32'(GAP_CYCLES - 1) : 32'd0;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_WRITE, S_GAP, S_DELAY, S_DONE, S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic [AW-1:0] err_index_q, err_index_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          pend_q, pend_d;      // GAP ends in a reissue rather than an advance
    logic [31:0]   cnt_q, cnt_d;        // shared by GAP and DELAY
    logic          wr_req_q, wr_req_d;
    logic [7:0]    wr_dev_q, wr_dev_d;
    logic [7:0]    wr_reg_q, wr_reg_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          advance;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= '0;
            err_index_q <= '0;
            retry_q     <= '0;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            wr_req_q    <= 1'b0;
            wr_dev_q    <= '0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            err_index_q <= err_index_d;
            retry_q     <= retry_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            wr_req_q    <= wr_req_d;
            wr_dev_q    <= wr_dev_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        err_index_d = err_index_q;
        retry_d     = retry_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        wr_req_d    = wr_req_q;
        wr_dev_d    = wr_dev_q;
        wr_reg_d    = wr_reg_q;
        wr_data_d   = wr_data_q;
        done_d      = done_q;
        error_d     = error_q;
        advance     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    rom_addr_d  = '0;
                    retry_d     = '0;
                    pend_d      = 1'b0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    err_index_d = '0;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                cnt_d = '0;
                if (rom_data == 16'hFFFF) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (rom_data == 16'hFFF0) begin
                    state_d = S_DELAY;
                end else begin
                    wr_dev_d  = DEV_ADDR;
                    wr_reg_d  = rom_data[15:8];
                    wr_data_d = rom_data[7:0];
                    wr_req_d  = 1'b1;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_ack) begin
                    wr_req_d = 1'b0;
                    cnt_d    = '0;
                    if (!wr_nack) begin
                        pend_d = 1'b0;
                        // COM7 soft reset needs the sensor to settle before the next write
                        state_d = (wr_reg_q == 8'h12 && wr_data_q[7]) ? S_DELAY : S_GAP;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        pend_d  = 1'b1;
                        state_d = S_GAP;
                    end else begin
                        err_index_d = rom_addr_q;
                        error_d     = 1'b1;
                        state_d     = S_ERROR;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    if (pend_q) begin
                        // re-read the same entry; rom_addr is left alone
                        pend_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DELAY: begin
                if (cnt_q == DELAY_LAST) advance = 1'b1;
                else                     cnt_d   = cnt_q + 32'd1;
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            retry_d = '0;
            if (rom_addr_q == AW'(NUM_REGS - 1)) begin
                // table has no sentinel: stop at the last slot instead of wrapping
                done_d  = 1'b1;
                state_d = S_DONE;
            end else begin
                rom_addr_d = rom_addr_q + 1'b1;
                state_d    = S_FETCH;
            end
        end
    end

    assign rom_addr  = rom_addr_q;
    assign err_index = err_index_q;
    assign wr_req    = wr_req_q;
    assign wr_dev    = wr_dev_q;
    assign wr_reg    = wr_reg_q;
    assign wr_data   = wr_data_q;
    assign done      = done_q;
    assign error     = error_q;
    assign busy      = !(state_q inside {S_IDLE, S_DONE, S_ERROR});

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Bench for ov7670_cfg_sequencer: a registered ROM model, an I2C slave model that
// acks after a programmable delay (optionally NACKing one register), and a
// scoreboard of expected writes (reg, data, table index, cycles since last ack).
module tb_ov7670_cfg_sequencer;

    localparam int CLK_HZ   = 100_000;
    localparam int SETTLE   = 1;
    localparam int GAP      = 5;
    localparam int NREGS    = 4;
    localparam int DLY_CYC  = SETTLE * CLK_HZ / 1000;
    // ack edge -> count cycles -> FETCH -> DECODE -> wr_req, seen one negedge later
    localparam int GAP_EXP  = GAP + 3;
    localparam int DLY_EXP  = DLY_CYC + 3;

    logic        clk, reset_n, start;
    logic [1:0]  rom_addr, err_index;
    logic [15:0] rom_data;
    logic        wr_req, wr_ack, wr_nack, busy, done, error;
    logic [7:0]  wr_dev, wr_reg, wr_data;

    ov7670_cfg_sequencer #(
        .CLK_FREQ_HZ(CLK_HZ), .NUM_REGS(NREGS), .DEV_ADDR(8'h42),
        .SETTLE_MS(SETTLE), .GAP_CYCLES(GAP), .MAX_RETRY(3)
    ) dut (
        .Clk(clk), .reset_n(reset_n), .start(start), .rom_addr(rom_addr),
        .rom_data(rom_data), .wr_req(wr_req), .wr_dev(wr_dev), .wr_reg(wr_reg),
        .wr_data(wr_data), .wr_ack(wr_ack), .wr_nack(wr_nack), .busy(busy),
        .done(done), .error(error), .err_index(err_index)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [15:0] rom [NREGS];
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        logic [7:0] r;
        logic [7:0] d;
        int         idx;
        int         gap;   // -1: first write of a pass, gap not checked
    } wr_t;
    wr_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int ack_dly = 20;
    logic [7:0] nack_reg = 8'h00;
    int nack_left = 0;     // -1: NACK forever
    int cyc = 0;
    int last_ack = 0;

    // I2C slave model + scoreboard consumer
    initial begin : slave
        bit         seen;
        int         hold;
        logic [7:0] cap_r, cap_d;
        wr_t        e;
        seen = 1'b0; hold = 0; cap_r = '0; cap_d = '0;
        wr_ack = 1'b0; wr_nack = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            wr_ack = 1'b0; wr_nack = 1'b0;
            if (!wr_req) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1; hold = 0; cap_r = wr_reg; cap_d = wr_data;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got reg=%h data=%h idx=%0d, none required", wr_reg, wr_data, rom_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (wr_reg !== e.r || wr_data !== e.d || wr_dev !== 8'h42 ||
                        rom_addr !== e.idx[1:0] || (e.gap >= 0 && (cyc - last_ack) != e.gap)) begin
                        errors++;
                        $display("FAIL write_fields got dev=%h reg=%h data=%h idx=%0d gap=%0d, required dev=42 reg=%h data=%h idx=%0d gap=%0d",
                                 wr_dev, wr_reg, wr_data, rom_addr, cyc - last_ack, e.r, e.d, e.idx, e.gap);
                    end
                end
            end else begin
                hold++;
                if (hold == ack_dly) begin
                    checks++;
                    if (wr_reg !== cap_r || wr_data !== cap_d || wr_dev !== 8'h42) begin
                        errors++;
                        $display("FAIL write_stable got reg=%h data=%h dev=%h, required reg=%h data=%h dev=42",
                                 wr_reg, wr_data, wr_dev, cap_r, cap_d);
                    end
                    wr_ack = 1'b1;
                    if (cap_r == nack_reg && nack_left != 0) begin
                        wr_nack = 1'b1;
                        if (nack_left > 0) nack_left--;
                    end
                    last_ack = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #600_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic push_wr(input logic [7:0] r, input logic [7:0] d, input int idx, input int gap);
        wr_t e;
        e.r = r; e.d = d; e.idx = idx; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic load_rom(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int k;
        k = 0;
        while (!(done || error) && k < 5000) begin
            @(negedge clk); k++;
        end
        checks++;
        if (k >= 5000) begin
            errors++;
            $display("FAIL %s_timeout got no done/error within 5000 cycles, required done or error", name);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_end(input string name, input logic exp_done, input logic exp_err,
                             input logic [1:0] exp_eidx, input logic [1:0] exp_addr);
        checks++;
        if (done !== exp_done || error !== exp_err || busy !== 1'b0 || err_index !== exp_eidx ||
            rom_addr !== exp_addr || wr_req !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_end got done=%b error=%b busy=%b eidx=%0d addr=%0d req=%b left=%0d, required done=%b error=%b busy=0 eidx=%0d addr=%0d req=0 left=0",
                     name, done, error, busy, err_index, rom_addr, wr_req, exp_q.size(),
                     exp_done, exp_err, exp_eidx, exp_addr);
        end
        exp_q.delete();
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (wr_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || rom_addr !== 2'd0 ||
            err_index !== 2'd0 || wr_dev !== 8'h00 || wr_reg !== 8'h00 || wr_data !== 8'h00) begin
            errors++;
            $display("FAIL %s got req=%b busy=%b done=%b err=%b addr=%0d eidx=%0d dev=%h reg=%h data=%h, required all 0",
                     name, wr_req, busy, done, error, rom_addr, err_index, wr_dev, wr_reg, wr_data);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0;
        load_rom(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("post_reset_idle");
    endtask

    task automatic test_latency();
        load_rom(16'h3A04, 16'hFFFF, 16'h0000, 16'h0000);
        ack_dly = 20;
        push_wr(8'h3A, 8'h04, 0, -1);
        pulse_start();               // now in cycle 1 (FETCH)
        checks++;
        if (wr_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL latency_c1 got req=%b busy=%b, required req=0 busy=1", wr_req, busy);
        end
        @(negedge clk);              // cycle 2 (DECODE)
        checks++;
        if (wr_req !== 1'b0) begin
            errors++;
            $display("FAIL latency_c2 got req=%b, required 0", wr_req);
        end
        @(negedge clk);              // cycle 3
        checks++;
        if (wr_req !== 1'b1 || wr_dev !== 8'h42 || wr_reg !== 8'h3A || wr_data !== 8'h04) begin
            errors++;
            $display("FAIL latency_c3 got req=%b dev=%h reg=%h data=%h, required req=1 dev=42 reg=3a data=04",
                     wr_req, wr_dev, wr_reg, wr_data);
        end
        wait_end("latency");
        check_end("latency", 1'b1, 1'b0, 2'd0, 2'd1);
    endtask

    task automatic test_settle();
        load_rom(16'h1280, 16'h1101, 16'hFFFF, 16'h0000);
        push_wr(8'h12, 8'h80, 0, -1);
        push_wr(8'h11, 8'h01, 1, DLY_EXP);
        pulse_start();
        wait_end("settle");
        check_end("settle", 1'b1, 1'b0, 2'd0, 2'd2);
    endtask

    task automatic test_retry();
        load_rom(16'h2001, 16'h2102, 16'hFFFF, 16'h0000);
        nack_reg = 8'h21; nack_left = 2;
        push_wr(8'h20, 8'h01, 0, -1);
        push_wr(8'h21, 8'h02, 1, GAP_EXP);
        push_wr(8'h21, 8'h02, 1, GAP_EXP);
        push_wr(8'h21, 8'h02, 1, GAP_EXP);
        pulse_start();
        wait_end("retry");
        check_end("retry", 1'b1, 1'b0, 2'd0, 2'd2);
        nack_left = 0;
    endtask

    task automatic test_error();
        load_rom(16'h3001, 16'h3102, 16'h3203, 16'hFFFF);
        nack_reg = 8'h32; nack_left = -1;
        push_wr(8'h30, 8'h01, 0, -1);
        push_wr(8'h31, 8'h02, 1, GAP_EXP);
        for (int i = 0; i < 4; i++) push_wr(8'h32, 8'h03, 2, GAP_EXP);
        pulse_start();
        wait_end("error");
        check_end("error", 1'b0, 1'b1, 2'd2, 2'd2);
        nack_left = 0;
        push_wr(8'h30, 8'h01, 0, -1);
        push_wr(8'h31, 8'h02, 1, GAP_EXP);
        push_wr(8'h32, 8'h03, 2, GAP_EXP);
        pulse_start();
        checks++;
        if (error !== 1'b0 || err_index !== 2'd0 || busy !== 1'b1 || rom_addr !== 2'd0) begin
            errors++;
            $display("FAIL error_clear got error=%b eidx=%0d busy=%b addr=%0d, required error=0 eidx=0 busy=1 addr=0",
                     error, err_index, busy, rom_addr);
        end
        wait_end("error_restart");
        check_end("error_restart", 1'b1, 1'b0, 2'd0, 2'd3);
    endtask

    task automatic test_reset_mid_write();
        int k;
        load_rom(16'h4455, 16'hFFFF, 16'h0000, 16'h0000);
        ack_dly = 100;
        push_wr(8'h44, 8'h55, 0, -1);
        pulse_start();
        k = 0;
        while (!wr_req && k < 20) begin @(negedge clk); k++; end
        checks++;
        if (wr_req !== 1'b1) begin
            errors++;
            $display("FAIL midreset_req got req=%b, required 1", wr_req);
        end
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (wr_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_drop got req=%b busy=%b, required req=0 busy=0", wr_req, busy);
        end
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("midreset_idle");
        ack_dly = 20;
        push_wr(8'h44, 8'h55, 0, -1);
        pulse_start();
        wait_end("midreset_restart");
        check_end("midreset_restart", 1'b1, 1'b0, 2'd0, 2'd1);
    endtask

    task automatic test_back_to_back();
        int k;
        load_rom(16'h5001, 16'h5102, 16'h5203, 16'h5304);
        push_wr(8'h50, 8'h01, 0, -1);
        push_wr(8'h51, 8'h02, 1, GAP_EXP);
        push_wr(8'h52, 8'h03, 2, GAP_EXP);
        push_wr(8'h53, 8'h04, 3, GAP_EXP);
        pulse_start();
        k = 0;
        while (!done && k < 5000) begin
            @(negedge clk);
            start = (k == 10 || k == 27 || k == 40 || k == 75 || k == 110);
            k++;
        end
        start = 1'b0;
        wait_end("no_sentinel");
        check_end("no_sentinel", 1'b1, 1'b0, 2'd0, 2'd3);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0;
        test_reset();
        test_latency();
        test_settle();
        test_retry();
        test_error();
        test_reset_mid_write();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
